fibonacci_checker: RTL and testbench
====================================

# fibonacci_checker

Stream checker for the consuming end of the Fibonacci generator's output bus. It samples a valid-qualified WIDTH-bit stream and locks onto any two consecutive terms. It then verifies that every later term equals the modulo-2^WIDTH sum of the previous two, and reports match, mismatch and wrap events with running counters. It sits downstream of the generator in benches and in self-checking top-levels. After a mismatch it re-acquires the stream automatically.

## Interface
- WIDTH, 12, data width; all sums are taken modulo 2^WIDTH, matching the generator's truncation.
- CNT_W, 16, width of term_count.
- ERR_W, 8, width of err_count.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous soft restart; has priority over in_valid.
- in_valid  in  1  in_data holds a new term this cycle.
- in_data  in  WIDTH  term value.
- locked  out  1  two seeds captured; stream currently being tracked.
- match  out  1  one-cycle pulse: the tracked term was correct.
- mismatch  out  1  one-cycle pulse: the tracked term was wrong.
- wrap  out  1  one-cycle pulse: a correct term was produced by a sum that overflowed WIDTH bits.
- expected  out  WIDTH  next term the checker predicts; 0 when not locked.
- term_count  out  CNT_W  valid samples accepted since reset/clear; saturates at all-ones.
- err_count  out  ERR_W  mismatches since reset/clear; saturates at all-ones.

## Operation
- Internal registers: prev and cur (WIDTH bits each), and a 2-bit state: IDLE, SEED, LOCK.
- Reset value of every output: locked=0, match=0, mismatch=0, wrap=0, expected=0, term_count=0, err_count=0. prev, cur and state also reset, to 0, 0 and IDLE.
- clear=1 (sampled at the edge): same effect as reset. in_valid in that cycle is ignored and not counted.
- in_valid=0: state, prev, cur and the counters hold. match, mismatch and wrap are 0.
- IDLE, valid sample d:
  - cur<=d; state->SEED.
- SEED, valid sample d:
  - prev<=cur, cur<=d; state->LOCK; locked<=1.
  - expected<=(cur+d) mod 2^WIDTH.
- LOCK, valid sample d, with sum = prev+cur computed to WIDTH+1 bits:
  - d == sum[WIDTH-1:0]:
    - match pulse; wrap pulse if sum[WIDTH]=1.
    - prev<=cur, cur<=d.
    - expected<=(cur+d) mod 2^WIDTH.
  - Otherwise:
    - mismatch pulse; err_count+1 (saturating); locked<=0; expected<=0.
    - cur<=d; state->SEED. The offending term becomes the first seed of re-acquisition.
- Every valid sample that is not blocked by clear increments term_count, saturating.
- Zero terms are legal: 0,0 locks and predicts 0 forever.

## Timing
- All outputs are registered and update at the edge that samples in_valid=1.
- Latency from sample to flag is 1 cycle.
- Pulses last exactly one cycle per valid sample. Back-to-back valid samples give back-to-back pulses.
- Minimum lock latency: 2 valid samples. The first compare happens on the 3rd valid sample after reset, clear or mismatch.
- Reset is asynchronous mid-stream: all outputs clear immediately, regardless of the clock.
- match and mismatch are never high together. wrap implies match.

## Test plan
- Reset, then feed 0,1,1,2,3,5,8 back-to-back:
  - locked rises after the 2nd sample.
  - match pulses on samples 3–7; expected=13 at the end.
  - term_count=7, err_count=0.
- Wrap case: seed 1597,2584, then feed 85.
  - match=1 and wrap=1 (4181 mod 4096 = 85); expected=2669.
- Mismatch and re-acquisition: feed 0,1,1,2,4.
  - mismatch pulse on 4; locked=0; err_count=1.
  - Then feed 6,10: locked rises after 6, and 10 gives match.
- Gapped stream: 0,1,1,2 with 3 idle cycles (in_valid=0) between each sample.
  - Idle cycles leave flags at 0 and counters held.
  - Results are identical to the back-to-back case.
- Reset and clear:
  - Assert rst asynchronously (off a clock edge) mid-stream after 5 terms: all outputs drop to 0 at once.
  - Assert clear together with in_valid=1 carrying data 7: the checker returns to IDLE and term_count stays 0.
- Saturation: force 256+ mismatches (alternating 0,1,5 repeated).
  - err_count holds at 255 and does not wrap.

Source files
------------

// File: rtl/fibonacci_checker.sv
// Stream checker for a Fibonacci generator bus: locks onto two seed terms, then verifies
// each later term is the modulo-2^WIDTH sum of the previous two, with match/mismatch/wrap pulses.
module fibonacci_checker #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             match,
    output logic             mismatch,
    output logic             wrap,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] term_count,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEED = 2'd1;
    localparam logic [1:0] LOCK = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] prev_s;
    logic [WIDTH-1:0] cur_r;
    logic [WIDTH-1:0] cur_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] expected_s;
    logic             locked_s;
    logic             match_s;
    logic             mismatch_s;
    logic             wrap_s;
    logic [CNT_W-1:0] term_count_s;
    logic [ERR_W-1:0] err_count_s;

    // Next-state decode: seed capture, tracking compare and saturating counters.
    always_comb begin
        state_s      = state_r;
        prev_s       = prev_r;
        cur_s        = cur_r;
        expected_s   = expected;
        locked_s     = locked;
        match_s      = 1'b0;
        mismatch_s   = 1'b0;
        wrap_s       = 1'b0;
        term_count_s = term_count;
        err_count_s  = err_count;
        // Carry bit of the prediction is what flags a wrapped term.
        sum_s        = {1'b0, prev_r} + {1'b0, cur_r};
        if (in_valid) begin
            if (term_count != {CNT_W{1'b1}}) begin
                term_count_s = term_count + CNT_W'(1);
            end else begin
                term_count_s = term_count;
            end
            case (state_r)
                IDLE: begin
                    cur_s   = in_data;
                    state_s = SEED;
                end
                SEED: begin
                    prev_s     = cur_r;
                    cur_s      = in_data;
                    state_s    = LOCK;
                    locked_s   = 1'b1;
                    expected_s = cur_r + in_data;
                end
                LOCK: begin
                    if (in_data == sum_s[WIDTH-1:0]) begin
                        match_s    = 1'b1;
                        wrap_s     = sum_s[WIDTH];
                        prev_s     = cur_r;
                        cur_s      = in_data;
                        expected_s = cur_r + in_data;
                    end else begin
                        // The offending term seeds re-acquisition.
                        mismatch_s = 1'b1;
                        locked_s   = 1'b0;
                        expected_s = {WIDTH{1'b0}};
                        cur_s      = in_data;
                        state_s    = SEED;
                        if (err_count != {ERR_W{1'b1}}) begin
                            err_count_s = err_count + ERR_W'(1);
                        end else begin
                            err_count_s = err_count;
                        end
                    end
                end
                default: begin
                    state_s    = IDLE;
                    locked_s   = 1'b0;
                    expected_s = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs; clear acts as a synchronous restart over in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            prev_r     <= {WIDTH{1'b0}};
            cur_r      <= {WIDTH{1'b0}};
            locked     <= 1'b0;
            match      <= 1'b0;
            mismatch   <= 1'b0;
            wrap       <= 1'b0;
            expected   <= {WIDTH{1'b0}};
            term_count <= {CNT_W{1'b0}};
            err_count  <= {ERR_W{1'b0}};
        end else if (clear) begin
            state_r    <= IDLE;
            prev_r     <= {WIDTH{1'b0}};
            cur_r      <= {WIDTH{1'b0}};
            locked     <= 1'b0;
            match      <= 1'b0;
            mismatch   <= 1'b0;
            wrap       <= 1'b0;
            expected   <= {WIDTH{1'b0}};
            term_count <= {CNT_W{1'b0}};
            err_count  <= {ERR_W{1'b0}};
        end else begin
            state_r    <= state_s;
            prev_r     <= prev_s;
            cur_r      <= cur_s;
            locked     <= locked_s;
            match      <= match_s;
            mismatch   <= mismatch_s;
            wrap       <= wrap_s;
            expected   <= expected_s;
            term_count <= term_count_s;
            err_count  <= err_count_s;
        end
    end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Randomized and directed bench for fibonacci_checker against a queue-based reference model.
module tb_fibonacci_checker;

    localparam int WIDTH = 12;
    localparam int CNT_W = 16;
    localparam int ERR_W = 8;
    localparam int MOD   = 4096;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             locked;
    logic             match;
    logic             mismatch;
    logic             wrap;
    logic [WIDTH-1:0] expected;
    logic [CNT_W-1:0] term_count;
    logic [ERR_W-1:0] err_count;

    int checks;
    int fails;

    // Reference model: the last accepted terms of the current run, newest at the back.
    int mq[$];
    bit m_locked, m_match, m_mis, m_wrap;
    int m_exp, m_tc, m_ec;

    logic [39:0] obs;
    assign obs = {locked, match, mismatch, wrap, expected, term_count, err_count};

    fibonacci_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .match(match), .mismatch(mismatch), .wrap(wrap),
        .expected(expected), .term_count(term_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] mvec();
        return {m_locked, m_match, m_mis, m_wrap, 12'(m_exp), 16'(m_tc), 8'(m_ec)};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_locked = 1'b0; m_match = 1'b0; m_mis = 1'b0; m_wrap = 1'b0;
        m_exp = 0; m_tc = 0; m_ec = 0;
    endfunction

    function automatic void model_step(bit v, int d);
        int s;
        m_match = 1'b0; m_mis = 1'b0; m_wrap = 1'b0;
        if (!v) return;
        m_tc = (m_tc == 65535) ? 65535 : m_tc + 1;
        if (mq.size() < 2) begin
            mq.push_back(d);
        end else begin
            s = mq[0] + mq[1];
            if (d == s % MOD) begin
                m_match = 1'b1;
                m_wrap  = (s >= MOD);
                void'(mq.pop_front());
                mq.push_back(d);
            end else begin
                m_mis = 1'b1;
                m_ec  = (m_ec == 255) ? 255 : m_ec + 1;
                mq.delete();
                mq.push_back(d);
            end
        end
        m_locked = (mq.size() == 2);
        m_exp    = m_locked ? (mq[0] + mq[1]) % MOD : 0;
    endfunction

    task automatic drive(input bit v, input int d);
        in_valid = v;
        in_data  = 12'(d);
        @(posedge clk);
        #1;
        model_step(v, d);
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 12'd0;
        model_reset();
        #12;
        checks++;
        if (obs !== 40'h0) begin
            fails++; $display("FAIL reset_state: got %h want %h", obs, 40'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int seq[7] = '{0, 1, 1, 2, 3, 5, 8};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, seq[i]);
            checks++;
            if (obs !== mvec()) begin
                fails++; $display("FAIL basic_step%0d: got %h want %h", i, obs, mvec());
            end
            checks++;
            if (locked !== (i >= 1)) begin
                fails++; $display("FAIL basic_locked%0d: got %b want %b", i, locked, (i >= 1));
            end
            checks++;
            if (match !== (i >= 2)) begin
                fails++; $display("FAIL basic_match%0d: got %b want %b", i, match, (i >= 2));
            end
        end
        checks++;
        if (expected !== 12'd13 || term_count !== 16'd7 || err_count !== 8'd0) begin
            fails++; $display("FAIL basic_final: got exp=%0d tc=%0d ec=%0d want 13 7 0", expected, term_count, err_count);
        end
    endtask

    task automatic test_wrap();
        do_clear();
        drive(1'b1, 1597);
        drive(1'b1, 2584);
        drive(1'b1, 85);
        checks++;
        if (match !== 1'b1 || wrap !== 1'b1 || mismatch !== 1'b0 || expected !== 12'd2669) begin
            fails++; $display("FAIL wrap: got m=%b w=%b mm=%b exp=%0d want 1 1 0 2669", match, wrap, mismatch, expected);
        end
        checks++;
        if (obs !== mvec()) begin
            fails++; $display("FAIL wrap_model: got %h want %h", obs, mvec());
        end
    endtask

    task automatic test_mismatch();
        int seq[7] = '{0, 1, 1, 2, 4, 6, 10};
        do_clear();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, seq[i]);
            checks++;
            if (obs !== mvec()) begin
                fails++; $display("FAIL mismatch_step%0d: got %h want %h", i, obs, mvec());
            end
            if (i == 4) begin
                checks++;
                if (mismatch !== 1'b1 || match !== 1'b0 || locked !== 1'b0 || err_count !== 8'd1 || expected !== 12'd0) begin
                    fails++; $display("FAIL mismatch_pulse: got mm=%b m=%b l=%b ec=%0d exp=%0d want 1 0 0 1 0", mismatch, match, locked, err_count, expected);
                end
            end else if (i == 5) begin
                checks++;
                if (locked !== 1'b1 || expected !== 12'd10) begin
                    fails++; $display("FAIL reacquire_lock: got l=%b exp=%0d want 1 10", locked, expected);
                end
            end else if (i == 6) begin
                checks++;
                if (match !== 1'b1 || err_count !== 8'd1) begin
                    fails++; $display("FAIL reacquire_match: got m=%b ec=%0d want 1 1", match, err_count);
                end
            end
        end
    endtask

    task automatic test_gapped();
        int seq[4] = '{0, 1, 1, 2};
        do_clear();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[i]);
            checks++;
            if (obs !== mvec()) begin
                fails++; $display("FAIL gapped_sample%0d: got %h want %h", i, obs, mvec());
            end
            for (int g = 0; g < 3; g++) begin
                drive(1'b0, 0);
                checks++;
                if (match !== 1'b0 || mismatch !== 1'b0 || wrap !== 1'b0 || term_count !== 16'(i + 1) || obs !== mvec()) begin
                    fails++; $display("FAIL gapped_idle%0d_%0d: got %h want %h", i, g, obs, mvec());
                end
            end
        end
        checks++;
        if (locked !== 1'b1 || expected !== 12'd3 || term_count !== 16'd4 || err_count !== 8'd0) begin
            fails++; $display("FAIL gapped_final: got l=%b exp=%0d tc=%0d ec=%0d want 1 3 4 0", locked, expected, term_count, err_count);
        end
    endtask

    task automatic test_async_reset();
        int seq[5] = '{3, 4, 7, 11, 18};
        do_clear();
        for (int i = 0; i < 5; i++) drive(1'b1, seq[i]);
        checks++;
        if (obs !== mvec()) begin
            fails++; $display("FAIL pre_reset: got %h want %h", obs, mvec());
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 40'h0) begin
            fails++; $display("FAIL async_reset: got %h want %h", obs, 40'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_clear();
        drive(1'b1, 5);
        drive(1'b1, 8);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'd7;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        model_reset();
        checks++;
        if (obs !== 40'h0) begin
            fails++; $display("FAIL clear_with_valid: got %h want %h", obs, 40'h0);
        end
        drive(1'b1, 13);
        checks++;
        if (locked !== 1'b0 || match !== 1'b0 || mismatch !== 1'b0 || term_count !== 16'd1) begin
            fails++; $display("FAIL clear_idle: got l=%b m=%b mm=%b tc=%0d want 0 0 0 1", locked, match, mismatch, term_count);
        end
    endtask

    task automatic test_random();
        int d;
        bit v;
        do_clear();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (m_locked && $urandom_range(0, 7) != 0) d = m_exp;
            else d = $urandom_range(0, MOD - 1);
            drive(v, d);
            checks++;
            if (obs !== mvec()) begin
                fails++; $display("FAIL random_step%0d: got %h want %h", i, obs, mvec());
            end
            checks++;
            if ((match && mismatch) || (wrap && !match)) begin
                fails++; $display("FAIL random_flags%0d: got m=%b mm=%b w=%b", i, match, mismatch, wrap);
            end
        end
    endtask

    task automatic test_saturation();
        int pat[3] = '{0, 1, 5};
        do_clear();
        for (int r = 0; r < 260; r++) begin
            for (int k = 0; k < 3; k++) begin
                drive(1'b1, pat[k]);
                checks++;
                if (obs !== mvec()) begin
                    fails++; $display("FAIL sat_step%0d_%0d: got %h want %h", r, k, obs, mvec());
                end
            end
        end
        checks++;
        if (err_count !== 8'hFF || term_count !== 16'd780) begin
            fails++; $display("FAIL saturation: got ec=%0d tc=%0d want 255 780", err_count, term_count);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_mismatch();
        test_gapped();
        test_async_reset();
        test_clear();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
